// File: rtl/frame_serializer_if.sv
// Word-offer / serial-output bundle for frame_serializer.
interface frame_serializer_if #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
);
    logic [MAX_WIDTH-1:0] data_in;
    logic [CNT_W-1:0]     data_len;
    logic                 msb_first;
    logic                 par_odd;
    logic                 data_valid;
    logic                 ser_en;
    logic                 ready;
    logic                 busy;
    logic                 serial_out;
    logic                 ser_done;
    logic                 parity_out;

    // Word source / TX controller side
    modport master (
        output data_in, data_len, msb_first, par_odd, data_valid, ser_en,
        input  ready, busy, serial_out, ser_done, parity_out
    );

    // Serializer side
    modport slave (
        input  data_in, data_len, msb_first, par_odd, data_valid, ser_en,
        output ready, busy, serial_out, ser_done, parity_out
    );
endinterface

// File: rtl/frame_serializer.sv
// Parallel-to-serial frame engine: one-word holding buffer feeding a
// shift engine (IDLE/SHIFT/DONE) with selectable bit order and parity.
module frame_serializer #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    frame_serializer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 hold_full;
    logic [MAX_WIDTH-1:0] hold_data;
    logic [CNT_W-1:0]     hold_len;
    logic                 hold_msb;
    logic                 hold_odd;

    logic [MAX_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]     cnt;
    logic                 msb_lat;
    logic                 odd_lat;
    logic                 par_acc;
    logic                 serial_q;

    logic [CNT_W-1:0]     len_clamp;
    logic                 accept;
    logic                 load;
    logic                 shift_en;
    logic                 next_bit;

    // Length clamp: 0 or anything above MAX_WIDTH means a full word
    always_comb begin
        if (bus.data_len == '0 || bus.data_len > CNT_W'(MAX_WIDTH))
            len_clamp = CNT_W'(MAX_WIDTH);
        else
            len_clamp = bus.data_len;
    end

    assign accept   = bus.data_valid & ~hold_full;
    assign load     = (state == IDLE) & hold_full;
    assign shift_en = (state == SHIFT) & bus.ser_en;
    // MSB-first words are left-aligned at load, so the next bit is always at an end
    assign next_bit = msb_lat ? sreg[MAX_WIDTH-1] : sreg[0];

    // Holding buffer: filled on accept, emptied when the engine loads it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_len  <= '0;
            hold_msb  <= 1'b0;
            hold_odd  <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= bus.data_in;
            hold_len  <= len_clamp;
            hold_msb  <= bus.msb_first;
            hold_odd  <= bus.par_odd;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shift datapath: load from buffer, then shift one bit per enabled edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg     <= '0;
            cnt      <= '0;
            msb_lat  <= 1'b0;
            odd_lat  <= 1'b0;
            par_acc  <= 1'b0;
            serial_q <= 1'b0;
        end else if (load) begin
            sreg    <= hold_msb ? (hold_data << (CNT_W'(MAX_WIDTH) - hold_len)) : hold_data;
            cnt     <= hold_len;
            msb_lat <= hold_msb;
            odd_lat <= hold_odd;
            par_acc <= 1'b0;
        end else if (shift_en) begin
            sreg     <= msb_lat ? {sreg[MAX_WIDTH-2:0], 1'b0} : {1'b0, sreg[MAX_WIDTH-1:1]};
            serial_q <= next_bit;
            par_acc  <= par_acc ^ next_bit;
            cnt      <= cnt - CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hold_full) state_nxt = SHIFT;
            SHIFT:   if (bus.ser_en && cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (!bus.ser_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        bus.ready      = ~hold_full;
        bus.busy       = (state != IDLE);
        bus.serial_out = serial_q;
        bus.ser_done   = (state == DONE);
        bus.parity_out = (state == DONE) & (par_acc ^ odd_lat);
    end
endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer (MAX_WIDTH=8).
module tb_frame_serializer;
    localparam int MW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    frame_serializer_if #(.MAX_WIDTH(MW), .CNT_W(CW)) bus ();

    frame_serializer #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    logic exp_bits [16];
    int   exp_len;
    logic exp_par;

    logic [7:0] inj_d [2];
    logic [3:0] inj_l [2];
    logic       inj_m [2];
    logic       inj_o [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of bits in transmit order and the final parity
    task automatic model(input logic [7:0] d, input logic [3:0] lraw, input logic msb, input logic odd);
        exp_len = (lraw == 0 || int'(lraw) > MW) ? MW : int'(lraw);
        exp_par = odd;
        for (int i = 0; i < exp_len; i++) begin
            exp_bits[i] = msb ? d[exp_len - 1 - i] : d[i];
            exp_par     = exp_par ^ exp_bits[i];
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic [3:0] l, input logic m, input logic o);
        bus.data_in    = d;
        bus.data_len   = l;
        bus.msb_first  = m;
        bus.par_odd    = o;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    // Drive ser_en through SHIFT and DONE, checking every emitted bit
    task automatic shift_frame(input string tag, input int stall, input int inj_at);
        logic prev;
        int   nd;
        for (int i = 0; i < exp_len; i++) begin
            int ns;
            ns = 0;
            if (stall == 1) ns = $urandom_range(0, 2);
            else if (stall == 2) ns = (i % 2 == 1) ? 2 : 0;
            for (int s = 0; s < ns; s++) begin
                prev = bus.serial_out;
                bus.ser_en = 1'b0;
                tick();
                chk({tag, "_stall_hold"}, bus.serial_out, prev);
                chk({tag, "_stall_done"}, bus.ser_done, 1'b0);
            end
            if (i == inj_at) begin
                chk({tag, "_ready_in_shift"}, bus.ready, 1'b1);
                bus.data_in = inj_d[0]; bus.data_len = inj_l[0];
                bus.msb_first = inj_m[0]; bus.par_odd = inj_o[0];
                bus.data_valid = 1'b1;
            end else if (i == inj_at + 1) begin
                chk({tag, "_ready_full"}, bus.ready, 1'b0);
                bus.data_in = inj_d[1]; bus.data_len = inj_l[1];
                bus.msb_first = inj_m[1]; bus.par_odd = inj_o[1];
                bus.data_valid = 1'b1;
            end
            bus.ser_en = 1'b1;
            tick();
            bus.data_valid = 1'b0;
            chk($sformatf("%s_bit%0d", tag, i), bus.serial_out, exp_bits[i]);
            chk($sformatf("%s_done%0d", tag, i), bus.ser_done, logic'(i == exp_len - 1));
        end
        chk({tag, "_parity"}, bus.parity_out, exp_par);
        chk({tag, "_busy_done"}, bus.busy, 1'b1);
        nd = $urandom_range(0, 2);
        for (int k = 0; k < nd; k++) begin
            bus.ser_en = 1'b1;
            tick();
            chk({tag, "_done_stay"}, bus.ser_done, 1'b1);
            chk({tag, "_done_hold"}, bus.serial_out, exp_bits[exp_len - 1]);
        end
        bus.ser_en = 1'b0;
        tick();
        chk({tag, "_done_exit"}, bus.ser_done, 1'b0);
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk({tag, "_idle_par"}, bus.parity_out, 1'b0);
    endtask

    // Offer a word to an idle engine, check the 2-edge load latency, shift it out
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] l,
                             input logic m, input logic o, input int stall);
        logic prev;
        model(d, l, m, o);
        chk({tag, "_ready_pre"}, bus.ready, 1'b1);
        prev = bus.serial_out;
        bus.ser_en = 1'($urandom);
        offer(d, l, m, o);
        chk({tag, "_ready_acc"}, bus.ready, 1'b0);
        chk({tag, "_busy_acc"}, bus.busy, 1'b0);
        bus.ser_en = 1'($urandom);
        tick();
        chk({tag, "_busy_load"}, bus.busy, 1'b1);
        chk({tag, "_ready_load"}, bus.ready, 1'b1);
        chk({tag, "_idle_hold"}, bus.serial_out, prev);
        shift_frame(tag, stall, -5);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;
        bus.data_in    = '0;
        bus.data_len   = '0;
        bus.msb_first  = 1'b0;
        bus.par_odd    = 1'b0;
        bus.data_valid = 1'b0;
        bus.ser_en     = 1'b0;

        // Reset values
        #3;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_serial", bus.serial_out, 1'b0);
        chk("rst_done", bus.ser_done, 1'b0);
        chk("rst_par", bus.parity_out, 1'b0);
        #9 rst = 1'b1;
        tick();

        // Directed frames
        run_frame("lsb_a5", 8'hA5, 4'd8, 1'b0, 1'b0, 0);
        run_frame("msb_15", 8'h15, 4'd5, 1'b1, 1'b1, 0);
        run_frame("stall", 8'hC9, 4'd8, 1'b0, 1'b1, 2);
        run_frame("clamp0", 8'hFF, 4'd0, 1'b0, 1'b0, 0);
        run_frame("clamp12", 8'hFF, 4'd12, 1'b1, 1'b0, 0);

        // Back-to-back: 0x3C accepted mid-frame, 0x99 offered while full is dropped
        inj_d[0] = 8'h3C; inj_l[0] = 4'd8; inj_m[0] = 1'b0; inj_o[0] = 1'b0;
        inj_d[1] = 8'h99; inj_l[1] = 4'd8; inj_m[1] = 1'b1; inj_o[1] = 1'b1;
        model(8'hF0, 4'd8, 1'b0, 1'b0);
        offer(8'hF0, 4'd8, 1'b0, 1'b0);
        tick();
        chk("b2b_a_busy", bus.busy, 1'b1);
        shift_frame("b2b_a", 0, 2);
        chk("b2b_pending", bus.ready, 1'b0);
        model(8'h3C, 4'd8, 1'b0, 1'b0);
        prev = bus.serial_out;
        bus.ser_en = 1'($urandom);
        tick();
        chk("b2b_b_busy", bus.busy, 1'b1);
        chk("b2b_b_hold", bus.serial_out, prev);
        shift_frame("b2b_b", 0, -5);
        repeat (3) tick();
        chk("b2b_drop_busy", bus.busy, 1'b0);
        chk("b2b_drop_ready", bus.ready, 1'b1);

        // Reset mid-SHIFT
        offer(8'hB7, 4'd8, 1'b0, 1'b1);
        tick();
        bus.ser_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", bus.ready, 1'b1);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_serial", bus.serial_out, 1'b0);
        chk("mid_rst_done", bus.ser_done, 1'b0);
        chk("mid_rst_par", bus.parity_out, 1'b0);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_busy", bus.busy, 1'b0);
            chk("post_rst_serial", bus.serial_out, 1'b0);
        end
        bus.ser_en = 1'b0;
        run_frame("post_rst", 8'h6D, 4'd7, 1'b1, 1'b0, 0);

        // Randomized frames
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic [3:0] l;
            d = 8'($urandom);
            l = 4'($urandom);
            run_frame($sformatf("rnd%0d", n), d, l, 1'($urandom), 1'($urandom), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
